// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and default data width.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU model: result modulo 2^WIDTH plus zero flag.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] expected_o,
    output logic             exp_zero_o
);

    always_comb begin
        expected_o = '0;
        case (op_i)
            ALU_ADD: expected_o = a_i + b_i;
            ALU_SUB: expected_o = a_i - b_i;
            ALU_AND: expected_o = a_i & b_i;
            ALU_OR:  expected_o = a_i | b_i;
            default: expected_o = '0;
        endcase
    end

    assign exp_zero_o = (expected_o == '0);

endmodule

// File: rtl/alu_check_monitor.sv
// Two-stage self-checking monitor for the 16-bit ALU with saturating pass/fail counters.
// Define ALU_CHK_CAPTURE_EN to add the first-mismatch capture ports.
module alu_check_monitor
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] Data_A,
    input  logic [WIDTH-1:0] Data_B,
    input  logic [1:0]       op_sel,
    input  logic [WIDTH-1:0] ALU_out,
    input  logic             Zero,
    output logic             chk_valid,
    output logic             mismatch,
    output logic [WIDTH-1:0] expected,
    output logic             any_error,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] err_count
`ifdef ALU_CHK_CAPTURE_EN
    ,
    output logic             first_err_valid,
    output logic [1:0]       first_err_op,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic [WIDTH-1:0] first_err_got
`endif
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             vld_p1_q;
    logic [WIDTH-1:0] a_p1_q, b_p1_q, got_p1_q;
    logic [1:0]       op_p1_q;
    logic             zero_p1_q;

    logic             vld_p2_q, mis_p2_q;
    logic [WIDTH-1:0] exp_p2_q;
    logic             any_err_q, any_err_d;
    logic [CNT_W-1:0] pass_q, pass_d, err_q, err_d;

    logic [WIDTH-1:0] exp_w;
    logic             exp_zero_w, mis_w;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a_i        (a_p1_q),
        .b_i        (b_p1_q),
        .op_i       (op_p1_q),
        .expected_o (exp_w),
        .exp_zero_o (exp_zero_w)
    );

    assign mis_w = (got_p1_q != exp_w) || (zero_p1_q != exp_zero_w);

    always_comb begin
        any_err_d = any_err_q;
        pass_d    = pass_q;
        err_d     = err_q;
        if (vld_p1_q) begin
            if (mis_w) begin
                err_d     = sat_inc(err_q);
                any_err_d = 1'b1;
            end else begin
                pass_d = sat_inc(pass_q);
            end
        end
    end

`ifdef ALU_CHK_CAPTURE_EN
    logic             fe_vld_q;
    logic [1:0]       fe_op_q;
    logic [WIDTH-1:0] fe_a_q, fe_b_q, fe_got_q;
`endif

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            vld_p1_q  <= 1'b0;
            a_p1_q    <= '0;
            b_p1_q    <= '0;
            got_p1_q  <= '0;
            op_p1_q   <= '0;
            zero_p1_q <= 1'b0;
            vld_p2_q  <= 1'b0;
            mis_p2_q  <= 1'b0;
            exp_p2_q  <= '0;
            any_err_q <= 1'b0;
            pass_q    <= '0;
            err_q     <= '0;
`ifdef ALU_CHK_CAPTURE_EN
            fe_vld_q  <= 1'b0;
            fe_op_q   <= '0;
            fe_a_q    <= '0;
            fe_b_q    <= '0;
            fe_got_q  <= '0;
`endif
        end else begin
            // S1: capture the transaction under check
            vld_p1_q <= in_valid;
            if (in_valid) begin
                a_p1_q    <= Data_A;
                b_p1_q    <= Data_B;
                got_p1_q  <= ALU_out;
                op_p1_q   <= op_sel;
                zero_p1_q <= Zero;
            end
            // S2: golden compare result, counters and sticky flag
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                exp_p2_q <= exp_w;
                mis_p2_q <= mis_w;
            end
            any_err_q <= any_err_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
`ifdef ALU_CHK_CAPTURE_EN
            if (vld_p1_q && mis_w && !fe_vld_q) begin
                fe_vld_q <= 1'b1;
                fe_op_q  <= op_p1_q;
                fe_a_q   <= a_p1_q;
                fe_b_q   <= b_p1_q;
                fe_got_q <= got_p1_q;
            end
`endif
        end
    end

    assign chk_valid  = vld_p2_q;
    assign mismatch   = mis_p2_q;
    assign expected   = exp_p2_q;
    assign any_error  = any_err_q;
    assign pass_count = pass_q;
    assign err_count  = err_q;

`ifdef ALU_CHK_CAPTURE_EN
    assign first_err_valid = fe_vld_q;
    assign first_err_op    = fe_op_q;
    assign first_err_a     = fe_a_q;
    assign first_err_b     = fe_b_q;
    assign first_err_got   = fe_got_q;
`endif

endmodule

// File: tb/tb_alu_check_monitor.sv
// Directed bench for alu_check_monitor (CNT_W=4); checks capture ports when ALU_CHK_CAPTURE_EN is defined.
module tb_alu_check_monitor;

    localparam int W = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, clear, in_valid;
    logic [W-1:0]  Data_A, Data_B, ALU_out;
    logic [1:0]    op_sel;
    logic          Zero;
    logic          chk_valid, mismatch, any_error;
    logic [W-1:0]  expected;
    logic [CW-1:0] pass_count, err_count;
`ifdef ALU_CHK_CAPTURE_EN
    logic          first_err_valid;
    logic [1:0]    first_err_op;
    logic [W-1:0]  first_err_a, first_err_b, first_err_got;
`endif

    int checks = 0;
    int errors = 0;

    alu_check_monitor #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .Data_A     (Data_A),
        .Data_B     (Data_B),
        .op_sel     (op_sel),
        .ALU_out    (ALU_out),
        .Zero       (Zero),
        .chk_valid  (chk_valid),
        .mismatch   (mismatch),
        .expected   (expected),
        .any_error  (any_error),
        .pass_count (pass_count),
        .err_count  (err_count)
`ifdef ALU_CHK_CAPTURE_EN
        ,
        .first_err_valid (first_err_valid),
        .first_err_op    (first_err_op),
        .first_err_a     (first_err_a),
        .first_err_b     (first_err_b),
        .first_err_got   (first_err_got)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one transaction at the next edge, then drop in_valid.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic [W-1:0] got, input logic z);
        Data_A = a; Data_B = b; op_sel = op; ALU_out = got; Zero = z;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_chk_valid"}, 32'(chk_valid), 0);
        chk({tag, "_mismatch"}, 32'(mismatch), 0);
        chk({tag, "_expected"}, 32'(expected), 0);
        chk({tag, "_any_error"}, 32'(any_error), 0);
        chk({tag, "_pass"}, 32'(pass_count), 0);
        chk({tag, "_err"}, 32'(err_count), 0);
`ifdef ALU_CHK_CAPTURE_EN
        chk({tag, "_fe_valid"}, 32'(first_err_valid), 0);
        chk({tag, "_fe_a"}, 32'(first_err_a), 0);
        chk({tag, "_fe_got"}, 32'(first_err_got), 0);
`endif
    endtask

    initial begin
        logic [W-1:0] sa[4];
        logic [W-1:0] sb[4];
        logic [W-1:0] se[4];

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        Data_A = '0; Data_B = '0; op_sel = '0; ALU_out = '0; Zero = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // ADD pass with two-edge latency
        send(16'd20, 16'd20, 2'b00, 16'd40, 1'b0);
        chk("add_latency", 32'(chk_valid), 0);
        tick();
        chk("add_chk_valid", 32'(chk_valid), 1);
        chk("add_mismatch", 32'(mismatch), 0);
        chk("add_expected", 32'(expected), 40);
        chk("add_pass", 32'(pass_count), 1);
        tick();
        chk("add_strobe_end", 32'(chk_valid), 0);

        // SUB to zero, then wrong zero flag
        send(16'd20, 16'd20, 2'b01, 16'd0, 1'b1);
        tick();
        chk("sub_mismatch", 32'(mismatch), 0);
        chk("sub_expected", 32'(expected), 0);
        chk("sub_pass", 32'(pass_count), 2);
        send(16'd20, 16'd20, 2'b01, 16'd0, 1'b0);
        tick();
        chk("subz_chk_valid", 32'(chk_valid), 1);
        chk("subz_mismatch", 32'(mismatch), 1);
        chk("subz_any_error", 32'(any_error), 1);
        chk("subz_err", 32'(err_count), 1);
        chk("subz_pass", 32'(pass_count), 2);
`ifdef ALU_CHK_CAPTURE_EN
        chk("cap_valid", 32'(first_err_valid), 1);
        chk("cap_op", 32'(first_err_op), 1);
        chk("cap_a", 32'(first_err_a), 20);
        chk("cap_b", 32'(first_err_b), 20);
        chk("cap_got", 32'(first_err_got), 0);
`endif

        // Wrap-around ADD, AND, OR
        send(16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1);
        tick();
        chk("wrap_mismatch", 32'(mismatch), 0);
        chk("wrap_expected", 32'(expected), 0);
        send(16'hF0F0, 16'h0FF0, 2'b10, 16'h00F0, 1'b0);
        tick();
        chk("and_mismatch", 32'(mismatch), 0);
        chk("and_expected", 32'(expected), 32'h00F0);
        send(16'hF0F0, 16'h0FF0, 2'b11, 16'hFFF0, 1'b0);
        tick();
        chk("or_mismatch", 32'(mismatch), 0);
        chk("or_expected", 32'(expected), 32'hFFF0);
        chk("or_pass", 32'(pass_count), 5);

        // Second, different mismatch: sticky flag stays, capture unchanged
        send(16'd5, 16'd3, 2'b00, 16'd9, 1'b0);
        tick();
        chk("mis2_mismatch", 32'(mismatch), 1);
        chk("mis2_expected", 32'(expected), 8);
        chk("mis2_err", 32'(err_count), 2);
        chk("mis2_any_error", 32'(any_error), 1);
`ifdef ALU_CHK_CAPTURE_EN
        chk("cap2_op", 32'(first_err_op), 1);
        chk("cap2_a", 32'(first_err_a), 20);
        chk("cap2_got", 32'(first_err_got), 0);
`endif

        // Clear with a simultaneous in_valid: the transaction is dropped
        Data_A = 16'd1; Data_B = 16'd2; op_sel = 2'b00; ALU_out = 16'd3; Zero = 1'b0;
        in_valid = 1'b1; clear = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b0;
        chk_all_zero("clear");
        tick();
        chk("clear_drop", 32'(chk_valid), 0);
        tick();
        chk("clear_drop2", 32'(chk_valid), 0);

        // Streaming: four back-to-back transactions
        sa = '{16'd3, 16'd10, 16'h000C, 16'h000C};
        sb = '{16'd5, 16'd3,  16'h000A, 16'h000A};
        se = '{16'd8, 16'd7,  16'h0008, 16'h000E};
        for (int k = 0; k < 4; k++) begin
            Data_A = sa[k]; Data_B = sb[k]; op_sel = 2'(k); ALU_out = se[k]; Zero = 1'b0;
            in_valid = 1'b1;
            tick();
            if (k >= 1) begin
                chk("stream_chk_valid", 32'(chk_valid), 1);
                chk("stream_expected", 32'(expected), 32'(se[k-1]));
                chk("stream_mismatch", 32'(mismatch), 0);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("stream_last_valid", 32'(chk_valid), 1);
        chk("stream_last_expected", 32'(expected), 32'h000E);
        chk("stream_pass", 32'(pass_count), 4);
        chk("stream_err", 32'(err_count), 0);
        tick();
        chk("stream_end", 32'(chk_valid), 0);

        // Saturation of err_count at 15
        clear = 1'b1; tick(); clear = 1'b0;
        Data_A = 16'd1; Data_B = 16'd1; op_sel = 2'b00; ALU_out = 16'd0; Zero = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("sat_err", 32'(err_count), 15);
        chk("sat_any_error", 32'(any_error), 1);
        chk("sat_pass", 32'(pass_count), 0);
        tick();
        chk("sat_hold", 32'(err_count), 15);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("sat_clear_err", 32'(err_count), 0);
        chk("sat_clear_any", 32'(any_error), 0);

        // Reset while a transaction is in flight
        send(16'd7, 16'd1, 2'b00, 16'd0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("rst_flight");
        tick();
        chk("rst_flight_no_strobe", 32'(chk_valid), 0);
        chk("rst_flight_err", 32'(err_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
